// File: rtl/fetch_pkg.sv
// Shared widths, constants and the prefetch entry type for the fetch stage.
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready handshake carrying one instruction and its PC.
interface fetch_if;
   import fetch_pkg::*;

   logic               if_valid;
   logic               if_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [XLEN-1:0]    if_pc;

   modport master (output if_valid, output if_instr, output if_pc, input if_ready);
   modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush outranks push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wdata,
   output fetch_entry_t           rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Guard against overflow/underflow regardless of what the caller requests.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: storage is cleared too so the head reads zero out of reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge.
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, prefetch FIFO and redirect handling.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [XLEN-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   fetch_if.master            dec
);

   logic [XLEN-1:0]             fetch_pc;
   logic [XLEN-1:0]             target_pc;
   logic                        push;
   logic                        pop;
   logic                        full;
   logic                        empty;
   logic [$clog2(FIFO_DEPTH):0] count;
   fetch_entry_t                wr_entry;
   fetch_entry_t                head;

   // Word-align the redirect target so fetch_pc[1:0] is always zero.
   assign target_pc = redirect_pc & ~XLEN'(3);

   assign imem_addr = fetch_pc;
   assign pop       = dec.if_valid && dec.if_ready;
   assign push      = !redirect_valid && (!full || pop);

   assign wr_entry.pc    = fetch_pc;
   assign wr_entry.instr = imem_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n)              fetch_pc <= RESET_PC;
      else if (redirect_valid) fetch_pc <= target_pc;
      else if (push)           fetch_pc <= fetch_pc + XLEN'(PC_STEP);
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wr_entry),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign dec.if_valid = !empty;
   assign dec.if_instr = head.instr;
   assign dec.if_pc    = head.pc;

endmodule
